// File: rtl/i2c_master_byte_ctrl.sv
// Byte-level I2C master controller: sequences START / 8 data bits / ACK / STOP
// as single-bit commands to a downstream bit-timing PHY.
module i2c_master_byte_ctrl (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       req_valid_i,
  output logic       req_ready_o,
  input  logic       start_i,
  input  logic       stop_i,
  input  logic       read_i,
  input  logic       write_i,
  input  logic       ack_i,
  input  logic [7:0] wr_data_i,
  output logic [7:0] rd_data_o,
  output logic       ack_o,
  output logic       done_o,
  output logic       arb_lost_o,
  output logic [2:0] phy_cmd_o,
  output logic       phy_data_o,
  input  logic       phy_data_i,
  input  logic       phy_cmd_done_i,
  input  logic       phy_arb_lost_i
);

  localparam logic [2:0] CmdNop   = 3'd0;
  localparam logic [2:0] CmdStart = 3'd1;
  localparam logic [2:0] CmdStop  = 3'd2;
  localparam logic [2:0] CmdWrite = 3'd3;
  localparam logic [2:0] CmdRead  = 3'd4;

  typedef enum logic [2:0] {
    IDLE_S, START_S, WR_BIT_S, RD_BIT_S, WR_ACK_S, RD_ACK_S, STOP_S
  } state_e;

  state_e      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [7:0]  wr_data_q, wr_data_d;
  logic        stop_q, stop_d;
  logic        read_q, read_d;
  logic        write_q, write_d;
  logic        ack_req_q, ack_req_d;
  logic [7:0]  rd_data_q, rd_data_d;
  logic        ack_q, ack_d;
  logic        done_q, done_d;
  logic        arb_q, arb_d;
  logic [2:0]  cmd_q, cmd_d;
  logic        accept;

  assign req_ready_o = (state_q == IDLE_S);
  assign accept      = req_valid_i && req_ready_o;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    wr_data_d = wr_data_q;
    stop_d    = stop_q;
    read_d    = read_q;
    write_d   = write_q;
    ack_req_d = ack_req_q;
    rd_data_d = rd_data_q;
    ack_d     = ack_q;
    done_d    = 1'b0;
    arb_d     = 1'b0;

    unique case (state_q)
      IDLE_S: begin
        if (accept) begin
          wr_data_d = wr_data_i;
          stop_d    = stop_i;
          write_d   = write_i;
          // A simultaneous read request is dropped in favour of the write.
          read_d    = read_i & ~write_i;
          ack_req_d = ack_i;
          if (start_i)                  state_d = START_S;
          else if (write_i)             state_d = WR_BIT_S;
          else if (read_i)              state_d = RD_BIT_S;
          else if (stop_i)              state_d = STOP_S;
          else                          done_d  = 1'b1;
        end
      end
      START_S: begin
        if (phy_cmd_done_i) begin
          if (write_q)     state_d = WR_BIT_S;
          else if (read_q) state_d = RD_BIT_S;
          else if (stop_q) state_d = STOP_S;
          else begin
            state_d = IDLE_S;
            done_d  = 1'b1;
          end
        end
      end
      WR_BIT_S: begin
        if (phy_cmd_done_i) begin
          if (cnt_q == 3'd0) state_d = RD_ACK_S;
          else               cnt_d   = cnt_q - 3'd1;
        end
      end
      RD_BIT_S: begin
        if (phy_cmd_done_i) begin
          rd_data_d = {rd_data_q[6:0], phy_data_i};
          if (cnt_q == 3'd0) state_d = WR_ACK_S;
          else               cnt_d   = cnt_q - 3'd1;
        end
      end
      WR_ACK_S, RD_ACK_S: begin
        if (phy_cmd_done_i) begin
          if (state_q == RD_ACK_S) ack_d = phy_data_i;
          if (stop_q) state_d = STOP_S;
          else begin
            state_d = IDLE_S;
            done_d  = 1'b1;
          end
        end
      end
      STOP_S: begin
        if (phy_cmd_done_i) begin
          state_d = IDLE_S;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE_S;
    endcase

    // Arbitration loss overrides any completion seen in the same cycle.
    if (state_q != IDLE_S && phy_arb_lost_i) begin
      state_d   = IDLE_S;
      cnt_d     = cnt_q;
      rd_data_d = rd_data_q;
      ack_d     = ack_q;
      done_d    = 1'b0;
      arb_d     = 1'b1;
    end

    if ((state_d == WR_BIT_S || state_d == RD_BIT_S) && state_d != state_q) cnt_d = 3'd7;
  end

  // Command register tracks the next state so it changes on the sampling edge.
  always_comb begin
    cmd_d = CmdNop;
    unique case (state_d)
      START_S:  cmd_d = CmdStart;
      WR_BIT_S: cmd_d = CmdWrite;
      RD_BIT_S: cmd_d = CmdRead;
      WR_ACK_S: cmd_d = CmdWrite;
      RD_ACK_S: cmd_d = CmdRead;
      STOP_S:   cmd_d = CmdStop;
      default:  cmd_d = CmdNop;
    endcase
  end

  always_comb begin
    phy_data_o = 1'b1;
    unique case (state_q)
      WR_BIT_S: phy_data_o = wr_data_q[cnt_q];
      WR_ACK_S: phy_data_o = ack_req_q;
      default:  phy_data_o = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= IDLE_S;
      cnt_q     <= 3'd0;
      wr_data_q <= 8'h00;
      stop_q    <= 1'b0;
      read_q    <= 1'b0;
      write_q   <= 1'b0;
      ack_req_q <= 1'b0;
      rd_data_q <= 8'h00;
      ack_q     <= 1'b1;
      done_q    <= 1'b0;
      arb_q     <= 1'b0;
      cmd_q     <= CmdNop;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      wr_data_q <= wr_data_d;
      stop_q    <= stop_d;
      read_q    <= read_d;
      write_q   <= write_d;
      ack_req_q <= ack_req_d;
      rd_data_q <= rd_data_d;
      ack_q     <= ack_d;
      done_q    <= done_d;
      arb_q     <= arb_d;
      cmd_q     <= cmd_d;
    end
  end

  assign rd_data_o  = rd_data_q;
  assign ack_o      = ack_q;
  assign done_o     = done_q;
  assign arb_lost_o = arb_q;
  assign phy_cmd_o  = cmd_q;

endmodule

// File: tb/tb_i2c_master_byte_ctrl.sv
// Directed bench for i2c_master_byte_ctrl: a one-cycle-per-command PHY responder
// logs the command stream, which is compared against hand-written expectations.
module tb_i2c_master_byte_ctrl;

  localparam logic [2:0] CmdNop   = 3'd0;
  localparam logic [2:0] CmdStart = 3'd1;
  localparam logic [2:0] CmdStop  = 3'd2;
  localparam logic [2:0] CmdWrite = 3'd3;
  localparam logic [2:0] CmdRead  = 3'd4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       start_f = 1'b0, stop_f = 1'b0, read_f = 1'b0, write_f = 1'b0, ack_in = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic [7:0] rd_data;
  logic       ack_out, done, arb_lost;
  logic [2:0] phy_cmd;
  logic       phy_dout;
  logic       phy_din = 1'b1;
  logic       phy_done = 1'b0;
  logic       phy_arb = 1'b0;

  int nchecks = 0;
  int nerrs   = 0;

  i2c_master_byte_ctrl dut (
    .clk_i          (clk),
    .rst_i          (rst),
    .req_valid_i    (req_valid),
    .req_ready_o    (req_ready),
    .start_i        (start_f),
    .stop_i         (stop_f),
    .read_i         (read_f),
    .write_i        (write_f),
    .ack_i          (ack_in),
    .wr_data_i      (wr_data),
    .rd_data_o      (rd_data),
    .ack_o          (ack_out),
    .done_o         (done),
    .arb_lost_o     (arb_lost),
    .phy_cmd_o      (phy_cmd),
    .phy_data_o     (phy_dout),
    .phy_data_i     (phy_din),
    .phy_cmd_done_i (phy_done),
    .phy_arb_lost_i (phy_arb)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       st, sp, rd, wr, ack;
    logic [7:0] wdat;
    logic [8:0] stream;   // bits returned to successive READ commands, bit 8 first
    string      cmds;     // S=START W=WRITE R=READ P=STOP
    string      wbits;    // phy_data_o seen on each WRITE command
    logic [7:0] exp_rd;
    logic       exp_ack;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    nchecks++;
    if (got !== exp) begin
      nerrs++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic check_str(input string name, input string got, input string exp);
    nchecks++;
    if (got != exp) begin
      nerrs++;
      $display("FAIL %s: got \"%s\" expected \"%s\"", name, got, exp);
    end
  endtask

  function automatic string cmd_char(input logic [2:0] c);
    case (c)
      CmdStart: return "S";
      CmdStop:  return "P";
      CmdWrite: return "W";
      CmdRead:  return "R";
      default:  return "?";
    endcase
  endfunction

  task automatic set_req(input logic st, sp, rd, wr, ack, input logic [7:0] d);
    req_valid = 1'b1;
    start_f = st; stop_f = sp; read_f = rd; write_f = wr; ack_in = ack; wr_data = d;
  endtask

  task automatic clr_req();
    req_valid = 1'b0;
    start_f = 1'b0; stop_f = 1'b0; read_f = 1'b0; write_f = 1'b0; ack_in = 1'b0;
    wr_data = 8'h00;
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    string got_c, got_w, tag;
    int    rd_i;
    bit    seen;
    got_c = ""; got_w = ""; rd_i = 8; seen = 1'b0;
    tag = $sformatf("v%0d", idx);
    @(negedge clk);
    check({tag, ".ready"}, {31'd0, req_ready}, 32'd1);
    set_req(v.st, v.sp, v.rd, v.wr, v.ack, v.wdat);
    @(negedge clk);
    clr_req();
    for (int c = 0; c < 40; c++) begin
      phy_done = 1'b0;
      if (done) begin
        seen = 1'b1;
        break;
      end
      if (phy_cmd != CmdNop) begin
        got_c = {got_c, cmd_char(phy_cmd)};
        if (phy_cmd == CmdWrite) got_w = {got_w, phy_dout ? "1" : "0"};
        if (phy_cmd == CmdRead) begin
          phy_din = (rd_i >= 0) ? v.stream[rd_i] : 1'b1;
          rd_i--;
        end
        phy_done = 1'b1;
      end
      @(negedge clk);
    end
    phy_done = 1'b0;
    check({tag, ".done_seen"}, {31'd0, seen}, 32'd1);
    check({tag, ".ready_on_done"}, {31'd0, req_ready}, 32'd1);
    check({tag, ".cmd_nop_on_done"}, {29'd0, phy_cmd}, {29'd0, CmdNop});
    check_str({tag, ".cmds"}, got_c, v.cmds);
    check_str({tag, ".wbits"}, got_w, v.wbits);
    check({tag, ".rd_data"}, {24'd0, rd_data}, {24'd0, v.exp_rd});
    check({tag, ".ack_o"}, {31'd0, ack_out}, {31'd0, v.exp_ack});
    @(negedge clk);
    check({tag, ".done_one_cycle"}, {31'd0, done}, 32'd0);
  endtask

  initial begin
    bit seen;
    //          st    sp    rd    wr    ack   wdat   stream            cmds           wbits       rd     ack
    vecs[0] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 8'hA5, 9'b0_0000_0000, "SWWWWWWWWRP", "10100101", 8'h00, 1'b0};
    vecs[1] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00, {8'h3C, 1'b0},  "RRRRRRRRW",   "1",        8'h3C, 1'b0};
    vecs[2] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 9'd0,           "",            "",         8'h3C, 1'b0};
    vecs[3] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 8'h3C, 9'b1_0000_0000, "SWWWWWWWWR",  "00111100", 8'h3C, 1'b1};
    vecs[4] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00, {8'h81, 1'b0},  "SRRRRRRRRWP", "0",        8'h81, 1'b1};
    vecs[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 9'd0,           "P",           "",         8'h81, 1'b1};
    vecs[6] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 9'd0,           "S",           "",         8'h81, 1'b1};
    vecs[7] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'hFF, 9'b0_0000_0000, "WWWWWWWWR",   "11111111", 8'h81, 1'b0};

    // Reset values.
    repeat (3) @(negedge clk);
    check("rst.cmd", {29'd0, phy_cmd}, {29'd0, CmdNop});
    check("rst.phy_data", {31'd0, phy_dout}, 32'd1);
    check("rst.rd_data", {24'd0, rd_data}, 32'd0);
    check("rst.ack", {31'd0, ack_out}, 32'd1);
    check("rst.done", {31'd0, done}, 32'd0);
    check("rst.arb", {31'd0, arb_lost}, 32'd0);
    check("rst.ready", {31'd0, req_ready}, 32'd1);
    rst = 1'b0;

    for (int i = 0; i < 8; i++) run_vec(i, vecs[i]);

    // Arbitration loss on bit 3 of a write, coinciding with a command-done pulse.
    @(negedge clk);
    set_req(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 8'hA5);
    @(negedge clk);
    clr_req();
    for (int b = 0; b < 4; b++) begin
      phy_done = 1'b1;
      @(negedge clk);
    end
    check("arb.cmd_before", {29'd0, phy_cmd}, {29'd0, CmdWrite});
    check("arb.bit3_data", {31'd0, phy_dout}, 32'd0);
    phy_done = 1'b1;
    phy_arb  = 1'b1;
    @(negedge clk);
    phy_done = 1'b0;
    phy_arb  = 1'b0;
    check("arb.cmd_nop", {29'd0, phy_cmd}, {29'd0, CmdNop});
    check("arb.pulse", {31'd0, arb_lost}, 32'd1);
    check("arb.no_done", {31'd0, done}, 32'd0);
    check("arb.ready", {31'd0, req_ready}, 32'd1);
    check("arb.rd_kept", {24'd0, rd_data}, 32'h81);
    check("arb.ack_kept", {31'd0, ack_out}, 32'd0);
    @(negedge clk);
    check("arb.pulse_once", {31'd0, arb_lost}, 32'd0);
    check("arb.no_done2", {31'd0, done}, 32'd0);

    // PHY pulses while idle are ignored.
    phy_done = 1'b1;
    phy_arb  = 1'b1;
    @(negedge clk);
    phy_done = 1'b0;
    phy_arb  = 1'b0;
    check("idle.no_arb", {31'd0, arb_lost}, 32'd0);
    check("idle.no_done", {31'd0, done}, 32'd0);
    check("idle.cmd", {29'd0, phy_cmd}, {29'd0, CmdNop});
    @(negedge clk);
    check("idle.no_arb2", {31'd0, arb_lost}, 32'd0);
    check("idle.no_done2", {31'd0, done}, 32'd0);

    // Back-to-back STOP requests with req_valid held high.
    set_req(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    @(negedge clk);
    check("b2b.first_cmd", {29'd0, phy_cmd}, {29'd0, CmdStop});
    phy_done = 1'b1;
    @(negedge clk);
    phy_done = 1'b0;
    check("b2b.done1", {31'd0, done}, 32'd1);
    check("b2b.ready_on_done", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    clr_req();
    check("b2b.second_cmd", {29'd0, phy_cmd}, {29'd0, CmdStop});
    check("b2b.done_low", {31'd0, done}, 32'd0);
    phy_done = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      phy_done = 1'b0;
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    check("b2b.done2", {31'd0, seen}, 32'd1);

    // Reset in the middle of a read byte.
    @(negedge clk);
    set_req(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 8'h00);
    @(negedge clk);
    clr_req();
    check("rrst.cmd_read", {29'd0, phy_cmd}, {29'd0, CmdRead});
    phy_din = 1'b1;
    for (int b = 0; b < 3; b++) begin
      phy_done = 1'b1;
      @(negedge clk);
    end
    phy_done = 1'b0;
    rst = 1'b1;
    #1;
    check("rrst.cmd", {29'd0, phy_cmd}, {29'd0, CmdNop});
    check("rrst.phy_data", {31'd0, phy_dout}, 32'd1);
    check("rrst.rd_data", {24'd0, rd_data}, 32'd0);
    check("rrst.ack", {31'd0, ack_out}, 32'd1);
    check("rrst.ready", {31'd0, req_ready}, 32'd1);
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("rrst.no_done", {31'd0, done}, 32'd0);
      check("rrst.no_arb", {31'd0, arb_lost}, 32'd0);
      check("rrst.idle_cmd", {29'd0, phy_cmd}, {29'd0, CmdNop});
    end

    $display("Result: errors=%0d of %0d checks", nerrs, nchecks);
    $finish;
  end

endmodule

// File: doc/i2c_master_byte_ctrl.md
I2C_MASTER_BYTE_CTRL -- requirements
Module: i2c_master_byte_ctrl

Interface
REQ-001 Clocking SHALL be one clock, clk_i; reset rst_i SHALL be asynchronous and active-high.
REQ-002 Parameters: none; the bit timing belongs to the downstream PHY.
REQ-003 clk_i  in  1  system clock.
REQ-004 rst_i  in  1  asynchronous active-high reset.
REQ-005 req_valid_i  in  1  host request valid.
REQ-006 req_ready_o  out  1  block can accept a request; high only in IDLE_S.
REQ-007 start_i, stop_i, read_i, write_i  in  1 each  request flags, sampled on accept.
REQ-008 ack_i  in  1  ACK bit to send after a read: 0 = ACK, 1 = NACK.
REQ-009 wr_data_i  in  8  byte to write, sent MSB first.
REQ-010 rd_data_o  out  8  received byte, MSB first.
REQ-011 ack_o  out  1  ACK bit sampled from the slave after a write.
REQ-012 done_o  out  1  one-cycle pulse marking request completion.
REQ-013 arb_lost_o  out  1  one-cycle pulse marking an aborted request.
REQ-014 phy_cmd_o  out  3  PHY command, using the i2c_pkg codes NOP, START, STOP, READ and WRITE.
REQ-015 phy_data_o  out  1  bit value for a PHY WRITE.
REQ-016 phy_data_i  in  1  bit value returned by a PHY READ.
REQ-017 phy_cmd_done_i  in  1  PHY command-complete pulse.
REQ-018 phy_arb_lost_i  in  1  PHY arbitration-lost pulse.

Function
REQ-019 Request acceptance SHALL occur on a cycle where req_valid_i and req_ready_o are both high.
- All flags, wr_data_i and ack_i are registered on accept.
- If read_i and write_i are both set, the block SHALL perform the write and ignore the read.
REQ-020 The FSM SHALL have these states: IDLE_S, START_S, WR_BIT_S, RD_BIT_S, WR_ACK_S, RD_ACK_S, STOP_S.
REQ-021 From IDLE_S, on accept, the FSM SHALL go to the first applicable state in this order:
- START_S if start_i is set.
- WR_BIT_S if write_i is set.
- RD_BIT_S if read_i is set.
- STOP_S if stop_i is set.
- If no flag is set, it SHALL stay in IDLE_S and pulse done_o on the following cycle.
REQ-022 Each non-IDLE state SHALL hold phy_cmd_o at its code (START, WRITE, READ, WRITE, READ, STOP respectively) from the cycle after entry until phy_cmd_done_i is seen.
- phy_cmd_o SHALL be registered and SHALL change on the same edge that samples phy_cmd_done_i.
- phy_cmd_o SHALL be NOP in IDLE_S.
REQ-023 Transition order:
- START_S -> write, read or stop stage, or IDLE_S if none is requested.
- WR_BIT_S -> RD_ACK_S after 8 bits.
- RD_BIT_S -> WR_ACK_S after 8 bits.
- Either ACK state -> STOP_S if stop is requested, else IDLE_S.
- STOP_S -> IDLE_S.
REQ-024 A 3-bit counter SHALL count the data bits.
- It loads 7 on entry to WR_BIT_S or RD_BIT_S and decrements on each phy_cmd_done_i.
- The bit stage exits on phy_cmd_done_i when the counter equals 0; the counter never wraps.
REQ-025 In WR_BIT_S, phy_data_o SHALL equal the byte bit indexed by the counter (MSB first).
- In WR_ACK_S it SHALL equal the registered ack_i.
- Elsewhere it SHALL be 1.
REQ-026 In RD_BIT_S, phy_data_i SHALL be shifted into rd_data_o LSB on each phy_cmd_done_i.
- rd_data_o SHALL hold its value otherwise.
REQ-027 In RD_ACK_S, ack_o SHALL be loaded with phy_data_i on phy_cmd_done_i.
REQ-028 done_o SHALL pulse for one cycle, coincident with the return to IDLE_S, after the last phy_cmd_done_i.
- req_ready_o SHALL be high on that same cycle.
REQ-029 phy_arb_lost_i in any non-IDLE state SHALL abort the request:
- the FSM goes to IDLE_S next cycle and phy_cmd_o goes to NOP;
- arb_lost_o pulses for one cycle;
- done_o SHALL NOT pulse;
- rd_data_o and ack_o keep their last values.
REQ-030 If phy_arb_lost_i and phy_cmd_done_i arrive in the same cycle, the arbitration loss SHALL win.
REQ-031 phy_arb_lost_i in IDLE_S SHALL be ignored.
REQ-032 phy_cmd_done_i in IDLE_S SHALL be ignored.

Reset
REQ-033 On rst_i the block SHALL set:
- state IDLE_S, phy_cmd_o NOP, phy_data_o 1;
- rd_data_o 0x00, ack_o 1, done_o 0, arb_lost_o 0, req_ready_o 1;
- all internal request registers cleared.
REQ-034 Reset asserted mid-transfer SHALL abort immediately, with no done_o and no arb_lost_o pulse.

Verification
REQ-035 Write with start, write and stop set, wr_data_i 0xA5, slave returning 0 on the ACK read -> phy_cmd_o sequence START, WRITE x8 with phy_data_o 1,0,1,0,0,1,0,1, READ, STOP; then ack_o=0 and one done_o pulse.
REQ-036 Read with read set, ack_i=1, phy_data_i bits 0,0,1,1,1,1,0,0 -> rd_data_o=0x3C; the ACK stage is a WRITE with phy_data_o=1; one done_o pulse.
REQ-037 phy_arb_lost_i during bit 3 of a write -> next cycle phy_cmd_o=NOP, arb_lost_o pulses once, no done_o, req_ready_o=1.
REQ-038 Back-to-back requests with req_valid_i held high -> second accepted on the done_o cycle; its first phy_cmd_o appears on the next cycle.
REQ-039 rst_i pulsed during RD_BIT_S -> all outputs at their reset values (REQ-033), no done_o pulse.
REQ-040 Request with no flags set -> done_o pulses on the cycle after accept; phy_cmd_o stays NOP.
